// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
// Push side of the UART transmit FIFO: controller writes bytes, FIFO reports back-pressure.
interface uart_tx_fifo_if;
  logic       write;
  logic [7:0] data_in;
  logic       full;
  logic       empty;

  modport master (output write, data_in, input  full, empty);
  modport slave  (input  write, data_in, output full, empty);
endinterface

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Byte FIFO feeding an 8N1 UART serializer; one frame per entry, LSB first, frames
// chained back-to-back while entries remain.
module uart_tx_fifo #(
  parameter int CLOCK_FEQ  = 25000000,
  parameter int BIT_RATE   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic          busy,
  output logic          tx
);
  localparam int CLKS_PER_BIT = CLOCK_FEQ / BIT_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_fifo: CLOCK_FEQ/BIT_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, count, count_next;
  logic           full_q, empty_q, push, pop;
  logic [7:0]     head;

  state_t         state, state_n;
  logic [BCW-1:0] baud, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_n, busy_n, bit_end;

  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign push      = bus.write & ~full_q;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign bit_end   = (baud == BCW'(CLKS_PER_BIT - 1));

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.data_in;
  end

  // full tracks the next count so a push can never overrun; empty trails count by one
  // clk, so a fresh entry reaches the serializer on the second edge after its write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full_q  <= (count_next == (AW+1)'(FIFO_DEPTH));
      empty_q <= (count == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    busy_n  = busy;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end else baud_n = baud + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // tx is registered, so the next bit is taken from shift[1] before the shift lands
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else baud_n = baud + 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else baud_n = baud + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Randomized bench for uart_tx_fifo: a frame-timing reference model predicts tx, busy,
// full and empty every clk; scenario tasks add explicit latency and decode checks.
module tb_uart_tx_fifo;
  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic clk, rst_n, busy, tx;
  uart_tx_fifo_if bus();

  uart_tx_fifo #(.CLOCK_FEQ(1000), .BIT_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .bus(bus), .busy(busy), .tx(tx));

  int checks = 0, failures = 0;
  int cyc = 0, m_start = 0, m_pops = 0, m_drops = 0;
  logic [7:0] mq[$];
  logic [7:0] m_byte = 8'h00;
  logic m_busy = 0, m_full = 0, m_empty = 1;
  logic e_tx = 1, e_busy = 0, e_full = 0, e_empty = 1;
  int   m_n, m_t;
  logic m_pop, m_push;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame occupies FRAME clks from its pop edge; pops happen when the
  // line is free (or a frame just ended) and the one-clk-late empty flag says data waits.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_full = 0; m_empty = 1;
    end else begin
      cyc++;
      m_n    = mq.size();
      m_push = bus.write && !m_full;
      if (bus.write && m_full) m_drops++;
      m_pop = 0;
      if (!m_busy) m_pop = !m_empty;
      else if (cyc - m_start == FRAME) begin
        m_pop  = !m_empty;
        m_busy = m_pop;
      end
      if (m_pop) begin
        m_byte = mq.pop_front(); m_start = cyc; m_busy = 1; m_pops++;
      end
      if (m_push) mq.push_back(bus.data_in);
      m_empty = (m_n == 0);
      m_full  = (mq.size() == DEPTH);
    end
    e_full = m_full; e_empty = m_empty; e_busy = m_busy;
    if (m_busy) begin
      m_t  = (cyc - m_start) / CPB;
      e_tx = (m_t == 0) ? 1'b0 : (m_t == 9) ? 1'b1 : m_byte[m_t-1];
    end else e_tx = 1'b1;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    if ({tx, busy, bus.full, bus.empty} !== 4'b1001) begin
      failures++; $display("FAIL reset_hold tx/busy/full/empty=%b expected 1001", {tx, busy, bus.full, bus.empty});
    end
    checks++;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
  endtask

  task automatic test_single();
    int k_fall = -1, nbusy = 0;
    bus.data_in = 8'h45; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      if (tx == 1'b0 && k_fall < 0) k_fall = k;
      if (busy) nbusy++;
      if (k == 5) begin
        if (bus.empty !== 1'b1) begin
          failures++; $display("FAIL single_empty_after_pop empty=%b expected 1", bus.empty);
        end
        checks++;
      end
      @(negedge clk);
    end
    if (k_fall != 2) begin
      failures++; $display("FAIL single_latency tx fell at +%0d expected +2", k_fall);
    end
    checks++;
    if (nbusy != FRAME) begin
      failures++; $display("FAIL single_busy_len busy=%0d clks expected %0d", nbusy, FRAME);
    end
    checks++;
  endtask

  task automatic test_fill();
    int first = -1, last = -1, nb = 0;
    for (int i = 0; i < 18 + 1800; i++) begin
      bus.write   = (i < 18);
      bus.data_in = 8'(i);
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL fill cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      if (busy) begin nb++; if (first < 0) first = i; last = i; end
      if (i == 17) begin
        if (bus.full !== 1'b1) begin
          failures++; $display("FAIL fill_full full=%b expected 1 after 18th push", bus.full);
        end
        checks++;
      end
    end
    if (first != 2) begin
      failures++; $display("FAIL fill_first_pop busy rose at +%0d expected +2", first);
    end
    checks++;
    if (nb != 17 * FRAME || last - first + 1 != 17 * FRAME) begin
      failures++; $display("FAIL fill_back_to_back busy=%0d span=%0d expected %0d", nb, last - first + 1, 17 * FRAME);
    end
    checks++;
  endtask

  task automatic test_full_drop();
    int p = -1, base;
    for (int i = 0; i < 17; i++) begin
      bus.write = 1'b1; bus.data_in = 8'($urandom);
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL full_drop_fill cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
    bus.data_in = 8'hAA;
    base = m_pops;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL full_drop cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      if (p < 0 && m_pops != base) begin
        p = i;
        if (bus.full !== 1'b0) begin
          failures++; $display("FAIL full_drop_fall full=%b expected 0 after pop", bus.full);
        end
        checks++;
      end else if (p >= 0 && i == p + 1) begin
        if (bus.full !== 1'b1) begin
          failures++; $display("FAIL full_drop_refill full=%b expected 1 after accepted push", bus.full);
        end
        checks++;
        bus.write = 1'b0;
      end
    end
    bus.write = 1'b0;
    if (p < 0) begin
      failures++; $display("FAIL full_drop_timeout pop never observed within 150 clks");
    end
    checks++;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL full_drop_drain cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [4];
    bit found = 0;
    bytes = '{8'h5A, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      bus.write = 1'b1; bus.data_in = bytes[i];
      @(negedge clk);
    end
    bus.write = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL reset_mid_pre cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      if (m_busy && cyc - m_start == 4 * CPB + 5) found = 1;
    end
    if (!found) begin
      failures++; $display("FAIL reset_mid_timeout bit 3 never reached");
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({tx, busy, bus.full, bus.empty} !== 4'b1001) begin
      failures++; $display("FAIL reset_mid_async tx/busy/full/empty=%b expected 1001", {tx, busy, bus.full, bus.empty});
    end
    checks++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({tx, busy} !== 2'b10) begin
        failures++; $display("FAIL reset_mid_quiet cyc=%0d tx/busy=%b expected 10", cyc, {tx, busy});
      end
      checks++;
    end
  endtask

  task automatic test_inflight();
    logic [7:0] x, got;
    logic [7:0] exp_b [3];
    logic cap [400];
    int s = -1, b;
    bit start_ok, stop_ok;
    x = 8'($urandom);
    exp_b = '{x, 8'hFF, 8'h00};
    for (int i = 0; i < 400; i++) begin
      bus.write   = (i == 0 || i == 30 || i == 31);
      bus.data_in = (i == 0) ? x : (i == 30) ? 8'hFF : 8'h00;
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL inflight cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      cap[i] = tx;
    end
    bus.write = 1'b0;
    for (int i = 0; i < 400; i++) if (s < 0 && cap[i] == 1'b0) s = i;
    if (s < 0 || s > 90) begin
      failures++; $display("FAIL inflight_start no start bit found (s=%0d)", s);
      checks++;
    end else begin
      for (int f = 0; f < 3; f++) begin
        b = s + FRAME * f;
        start_ok = 1; stop_ok = 1; got = 8'h00;
        for (int j = 0; j < CPB; j++) begin
          if (cap[b + j] != 1'b0) start_ok = 0;
          if (cap[b + 9 * CPB + j] != 1'b1) stop_ok = 0;
        end
        if (exp_b[f][0] && cap[b + CPB] != 1'b1) start_ok = 0;
        for (int j = 0; j < 8; j++) got[j] = cap[b + CPB + CPB / 2 + CPB * j];
        if (got !== exp_b[f] || !start_ok || !stop_ok) begin
          failures++; $display("FAIL inflight_decode frame %0d byte=%h start_ok=%0d stop_ok=%0d expected byte=%h", f, got, start_ok, stop_ok, exp_b[f]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_stop_edge();
    bit found = 0;
    bus.write = 1'b1; bus.data_in = 8'($urandom);
    @(negedge clk);
    bus.write = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL stop_edge_pre cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
      if (m_busy && cyc - m_start == FRAME - 2) found = 1;
    end
    if (!found) begin
      failures++; $display("FAIL stop_edge_timeout frame end never reached");
    end
    checks++;
    bus.write = 1'b1; bus.data_in = 8'h80;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    if ({tx, busy} !== 2'b10) begin
      failures++; $display("FAIL stop_edge_idle tx/busy=%b expected 10", {tx, busy});
    end
    checks++;
    @(negedge clk);
    if ({tx, busy} !== 2'b01) begin
      failures++; $display("FAIL stop_edge_start tx/busy=%b expected 01", {tx, busy});
    end
    checks++;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL stop_edge cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      bus.write   = ($urandom_range(0, 99) < ((i < 1500) ? 15 : 4));
      bus.data_in = 8'($urandom);
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
    bus.write = 1'b0;
    for (int i = 0; i < 1800; i++) begin
      @(negedge clk);
      if ({tx, busy, bus.full, bus.empty} !== {e_tx, e_busy, e_full, e_empty}) begin
        failures++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, {tx, busy, bus.full, bus.empty}, {e_tx, e_busy, e_full, e_empty});
      end
      checks++;
    end
    if ({busy, bus.empty} !== 2'b01) begin
      failures++; $display("FAIL random_final busy/empty=%b expected 01", {busy, bus.empty});
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0; bus.write = 1'b0; bus.data_in = 8'h00;
    test_reset();
    test_single();
    test_fill();
    test_full_drop();
    test_reset_mid();
    test_inflight();
    test_stop_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
